// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: run/idle sequencer and instruction loader for a RISC-V core.
// Edge-detects a run request and an instruction write request. It runs the core
// for a latched number of cycles and forwards instruction words to the imem
// write port while the core is not running.
// Optional feature: define RUN_CTRL_HALT_EN to add the i_core_halt input. When
// i_core_halt is high during RUN, the run ends early.
module riscv_run_ctrl #(
  parameter int unsigned IMEM_ADDR_W = 10
) (
  input  logic                   s00_axi_aclk,
  input  logic                   s00_axi_aresetn,
  input  logic                   i_run,
  input  logic [31:0]            i_num_cycle,
  input  logic                   i_mem_reset_n,
  input  logic                   i_instr_write,
  input  logic [31:0]            i_instr_data,
  input  logic [31:0]            i_instr_addr,
`ifdef RUN_CTRL_HALT_EN
  input  logic                   i_core_halt,
`endif
  output logic                   o_idle,
  output logic                   o_running,
  output logic                   o_done,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [31:0]            o_imem_wdata,
  output logic                   o_core_rst_n,
  output logic                   o_core_en,
  output logic [31:0]            o_cycle_cnt,
  output logic                   o_wr_err
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                   run_q, wr_q;
  logic                   run_rise, wr_rise, halt, run_start, run_last;
  logic [CNT_W-1:0]       num_q, num_d;
  logic [CNT_W-1:0]       cnt_d;
  logic                   idle_d, running_d, done_d, core_en_d, core_rst_n_d;
  logic                   imem_we_d, wr_err_d;
  logic [IMEM_ADDR_W-1:0] imem_addr_d;
  logic [DATA_W-1:0]      imem_wdata_d;
  logic                   unused_addr_bits;

  // Word-offset and out-of-range address bits are deliberately dropped.
  assign unused_addr_bits = ^{i_instr_addr[31:IMEM_ADDR_W+2], i_instr_addr[1:0]};

`ifdef RUN_CTRL_HALT_EN
  assign halt = i_core_halt;
`else
  assign halt = 1'b0;
`endif

  assign run_rise  = i_run & ~run_q;
  assign wr_rise   = i_instr_write & ~wr_q;
  assign run_start = (state_q == ST_IDLE) & run_rise & i_mem_reset_n;
  assign run_last  = (o_cycle_cnt == CNT_W'(num_q - CNT_W'(1))) | halt;

  // Previous-value registers for the run and write request edge detectors.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      run_q <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      run_q <= i_run;
      wr_q  <= i_instr_write;
    end
  end

  // FSM state register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A software abort wins over every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (run_rise) state_d = (i_num_cycle == CNT_W'(0)) ? ST_DONE : ST_RUN;
      ST_RUN:  if (run_last) state_d = ST_DONE;
      ST_DONE: if (!i_run)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!i_mem_reset_n) state_d = ST_IDLE;
  end

  // Next values of the registered outputs, the cycle counter and the latched run length.
  always_comb begin
    idle_d       = (state_d == ST_IDLE);
    running_d    = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
    core_en_d    = (state_d == ST_RUN);
    core_rst_n_d = (state_d != ST_IDLE);
    num_d        = num_q;
    cnt_d        = o_cycle_cnt;
    wr_err_d     = o_wr_err;
    imem_we_d    = 1'b0;
    imem_addr_d  = o_imem_addr;
    imem_wdata_d = o_imem_wdata;

    if (run_start) begin
      num_d    = i_num_cycle;
      cnt_d    = '0;
      wr_err_d = 1'b0;
    end

    if (state_q == ST_RUN) begin
      cnt_d = CNT_W'(o_cycle_cnt + CNT_W'(1));
    end

    // Instruction writes land only while the core is stopped; during RUN they are flagged.
    if (wr_rise) begin
      if (state_q == ST_RUN) begin
        wr_err_d = 1'b1;
      end else if (i_mem_reset_n) begin
        imem_we_d    = 1'b1;
        imem_addr_d  = i_instr_addr[IMEM_ADDR_W+1:2];
        imem_wdata_d = i_instr_data;
      end
    end

    if (!i_mem_reset_n) begin
      cnt_d = '0;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      o_idle       <= 1'b1;
      o_running    <= 1'b0;
      o_done       <= 1'b0;
      o_core_en    <= 1'b0;
      o_core_rst_n <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_cycle_cnt  <= '0;
      o_wr_err     <= 1'b0;
      num_q        <= '0;
    end else begin
      o_idle       <= idle_d;
      o_running    <= running_d;
      o_done       <= done_d;
      o_core_en    <= core_en_d;
      o_core_rst_n <= core_rst_n_d;
      o_imem_we    <= imem_we_d;
      o_imem_addr  <= imem_addr_d;
      o_imem_wdata <= imem_wdata_d;
      o_cycle_cnt  <= cnt_d;
      o_wr_err     <= wr_err_d;
      num_q        <= num_d;
    end
  end

endmodule

// File: doc/riscv_run_ctrl.md
RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 SHALL have parameter IMEM_ADDR_W, default 10, giving the instruction-memory word-address width.
REQ-002 SHALL have port s00_axi_aclk, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-003 SHALL have port s00_axi_aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_run, input, 1 bit: run request level; its rising edge starts a run.
REQ-005 SHALL have port i_num_cycle, input, 32 bits: number of core cycles to execute.
REQ-006 SHALL have port i_mem_reset_n, input, 1 bit: software abort/reset, active-low, sampled synchronously.
REQ-007 SHALL have port i_instr_write, input, 1 bit: instruction write request level; its rising edge is one write.
REQ-008 SHALL have port i_instr_data, input, 32 bits: instruction word.
REQ-009 SHALL have port i_instr_addr, input, 32 bits: instruction byte address.
REQ-010 SHALL have ports o_idle, o_running and o_done, output, 1 bit each: one-hot state status.
REQ-011 SHALL have port o_imem_we, output, 1 bit: instruction-memory write strobe.
REQ-012 SHALL have port o_imem_addr, output, IMEM_ADDR_W bits: the word address.
REQ-013 SHALL have port o_imem_wdata, output, 32 bits: write data.
REQ-014 SHALL have port o_core_rst_n, output, 1 bit: core reset, active-low.
REQ-015 SHALL have port o_core_en, output, 1 bit: core clock enable.
REQ-016 SHALL have port o_cycle_cnt, output, 32 bits: cycles executed in the current/last run.
REQ-017 SHALL have port o_wr_err, output, 1 bit: sticky flag for a write attempted during RUN.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; o_idle/o_running/o_done SHALL be registered and one-hot with the state.
REQ-019 In IDLE, a rising edge of i_run (registered edge detect) SHALL latch i_num_cycle, clear o_cycle_cnt and o_wr_err, and move to RUN, or to DONE when the latched value is 0.
REQ-020 In RUN, o_core_en=1 and o_cycle_cnt SHALL increment by 1 per clock; when o_cycle_cnt equals latched N-1 the next state SHALL be DONE, leaving o_cycle_cnt=N; RUN SHALL last exactly N cycles.
REQ-021 In DONE, o_core_en=0 and o_cycle_cnt SHALL hold; the FSM SHALL return to IDLE on the first cycle i_run is low.
REQ-022 o_core_rst_n SHALL be 0 in IDLE and 1 in RUN and DONE, so every run starts the core from reset.
REQ-023 A rising edge of i_instr_write in IDLE or DONE SHALL produce exactly one o_imem_we pulse on the next clock, with o_imem_addr=i_instr_addr[IMEM_ADDR_W+1:2] and o_imem_wdata=i_instr_data, both registered alongside the pulse.
REQ-024 Address bits above IMEM_ADDR_W+1 and bits [1:0] SHALL be ignored; addresses wrap modulo memory size.
REQ-025 A rising edge of i_instr_write in RUN SHALL produce no o_imem_we and SHALL set o_wr_err.
REQ-026 i_mem_reset_n=0 SHALL force the next state to IDLE from any state, clear o_cycle_cnt, and suppress o_imem_we; it overrides a simultaneous run edge.
REQ-027 A simultaneous run edge and write edge in IDLE SHALL perform the write (o_imem_we=1) and start the run.
REQ-028 Input changes of i_num_cycle during RUN SHALL have no effect.

Reset
REQ-029 On s00_axi_aresetn=0 the state SHALL be IDLE, o_idle=1, o_core_rst_n=0, all other outputs 0, and the edge-detect registers 0.
REQ-030 Reset mid-RUN SHALL abort immediately, with no o_imem_we pulse after reset release until a new rising edge of i_instr_write.

Configuration
REQ-031 With macro RUN_CTRL_HALT_EN defined, an input port i_core_halt, 1 bit, SHALL exist; i_core_halt=1 in RUN SHALL move the FSM to DONE next cycle, with o_cycle_cnt frozen at the count including that cycle.
REQ-032 Without RUN_CTRL_HALT_EN, the port SHALL be absent and a run SHALL always last N cycles.

Verification
REQ-033 Reset release, write edge with addr=0x0000_0008, data=0x0000_0013 -> one o_imem_we pulse, o_imem_addr=2, o_imem_wdata=0x13.
REQ-034 N=5, i_run rises -> o_running for exactly 5 clocks, o_core_en=1 for those 5 clocks, then o_done=1 with o_cycle_cnt=5; i_run low -> o_idle=1 next clock.
REQ-035 N=0, i_run rises -> o_done=1 with no RUN cycle and o_cycle_cnt=0.
REQ-036 Write edge during RUN with N=100 -> no o_imem_we, o_wr_err=1; o_wr_err cleared by the next run start.
REQ-037 i_mem_reset_n=0 at cycle 3 of an N=10 run -> IDLE next clock, o_cycle_cnt=0, o_core_rst_n=0.
REQ-038 With RUN_CTRL_HALT_EN, N=50 and i_core_halt pulsed at RUN cycle 7 -> o_done=1, o_cycle_cnt=7.
